uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each received byte on the receiver's rx_done strobe and presents bytes to the host through a registered read port. It also reports occupancy, almost-full, sticky overrun and a character-timeout flag, in the style of a 16550 RX FIFO. The timeout is timed in s_tick units from the shared baud generator.

Parameters:
DBIT, 8, data bits per character; matches the receiver.
ADDR_W, 4, address width; depth = 2**ADDR_W = 16.
AFULL_LVL, 12, almost_full asserts when count >= AFULL_LVL.
BIT_WIDTH, 16, s_ticks per bit; matches the receiver.
TOUT_CHARS, 4, idle character-times before timeout.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_tick  in  1  baud oversample tick, one clk wide
rx_done  in  1  one-cycle byte-valid strobe from receiver
rx_dout  in  DBIT  received byte, valid while rx_done=1
rd_en  in  1  host pop request
ovr_clr  in  1  clears overrun
rd_data  out  DBIT  registered read data
empty  out  1  count==0
full  out  1  count==2**ADDR_W
almost_full  out  1  count>=AFULL_LVL
count  out  ADDR_W+1  current occupancy
overrun  out  1  sticky; a byte was dropped
timeout  out  1  character timeout pending

Behaviour:
- Reset (async, rst_n=0):
  - Pointers, count and rd_data are 0; empty=1; full, almost_full, overrun and timeout are 0.
  - Timeout FSM enters T_IDLE. Memory contents are don't-care.
- Pointers are ADDR_W bits and wrap naturally from 2**ADDR_W-1 to 0. count is a separate ADDR_W+1-bit register.
- Read:
  - rd_en && !empty pops in that cycle. rd_data takes mem[rd_ptr] on the same clk edge, so data is visible one cycle after rd_en.
  - rd_en while empty is ignored; rd_data holds its value.
- Write:
  - rx_done && (!full || pop this cycle) writes rx_dout at wr_ptr.
- Simultaneous pop and write:
  - Both occur and count is unchanged, including when full (push-through).
  - When empty, only the write occurs, and rd_data is not updated that cycle.
- Overrun:
  - rx_done while full with no pop this cycle drops the byte and sets overrun on the next edge. Pointers and count are untouched.
  - ovr_clr clears overrun. If a drop and ovr_clr coincide, set wins.
- empty, full, almost_full are combinational decodes of registered count.
- Timeout FSM (tout_state_e), counter tcnt counts to TOUT_TICKS = TOUT_CHARS*(DBIT+2)*BIT_WIDTH (640 at defaults); width is $clog2 of that:
  - T_IDLE: when FIFO non-empty -> T_COUNT, tcnt=0.
  - T_COUNT: any accepted write or pop -> tcnt=0, stay. Otherwise s_tick increments tcnt. On s_tick with tcnt==TOUT_TICKS-1 -> T_FLAG. Becoming empty -> T_IDLE.
  - T_FLAG: timeout=1. Accepted write or pop -> T_COUNT, tcnt=0, timeout drops next cycle. Empty -> T_IDLE.
  - timeout is asserted only in T_FLAG (registered state decode).
- Reset mid-operation discards all contents and flags immediately. No pop or push completes on the reset edge.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined: timeout FSM, tcnt and timeout output exist as described above.
- Undefined: the FSM and counter are not elaborated. timeout is tied to 0. s_tick is unused.
- All other behaviour is identical in both cases.

Decomposition:
- Add tout_state_e {T_IDLE, T_COUNT, T_FLAG} to states_pkg, alongside the existing state_e.
- One sub-module, uart_rx_fifo_mem: simple dual-port register array (write port: wr_en/wr_addr/wr_data; registered read port: rd_en/rd_addr/rd_data).
- Pointer, count, flag and timeout logic stays in uart_rx_fifo.

Test Plan:
1. Reset while holding 5 bytes -> count=0, empty=1, rd_data=0, overrun=0, timeout=0 during rst_n=0.
2. Write 0x11..0x20 (16 bytes) -> full=1, almost_full from the 12th byte. Then 16 rd_en pulses -> rd_data 0x11..0x20 in order, one cycle after each rd_en; empty=1 at the end.
3. Fill to 16, then rx_done with 0xAA and no rd_en -> overrun=1, count=16, 0xAA never read. Pulse ovr_clr -> overrun=0.
4. Full FIFO, rx_done=0x55 with rd_en in the same cycle -> count stays 16, head byte is popped, 0x55 is read last after wrap-around.
5. rd_en on an empty FIFO -> count=0, rd_data unchanged, no pointer movement.
6. UART_RX_FIFO_TIMEOUT_EN defined; write one byte, then apply s_tick every cycle:
   - timeout rises after 640 ticks.
   - rd_en -> timeout falls, FSM returns to T_IDLE.
   - A second write at tick 600 restarts the count, so timeout is at tick 1240 from the first write.

Source files
------------

// File: rtl/states_pkg.sv
// states_pkg: shared FSM state types and helpers for the UART blocks.
//   state_e      - receiver bit-level states
//   tout_state_e - RX FIFO character-timeout states
//   tout_ticks() - s_ticks in TOUT_CHARS character times (start+data+stop bits)
package states_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    typedef enum logic [1:0] {T_IDLE, T_COUNT, T_FLAG} tout_state_e;

    function automatic int tout_ticks(input int chars, input int dbit, input int bit_width);
        return chars * (dbit + 2) * bit_width;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: simple dual-port register array with a registered read port.
//   clk, rst_n              - clock, async active-low reset (clears rd_data only)
//   wr_en, wr_addr, wr_data - write port
//   rd_en, rd_addr, rd_data - read port; rd_data updates on the edge rd_en is seen
module uart_rx_fifo_mem #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DBIT-1:0]   rd_data
);

    logic [DBIT-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A same-address write and read in one cycle returns the old word (push-through when full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style receive FIFO behind the UART receiver.
//   clk, rst_n         - clock, async active-low reset
//   s_tick             - baud oversample tick (timeout timing only)
//   rx_done, rx_dout   - byte strobe and data from the receiver
//   rd_en              - host pop; rd_data valid one cycle later
//   ovr_clr            - clears sticky overrun
//   rd_data, count, empty, full, almost_full, overrun, timeout - status/read port
// Optional: define UART_RX_FIFO_TIMEOUT_EN to build the character-timeout FSM;
// otherwise timeout is tied low and s_tick is unused.
module uart_rx_fifo
    import states_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 12,
    parameter int BIT_WIDTH  = 16,
    parameter int TOUT_CHARS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tick,
    input  logic              rx_done,
    input  logic [DBIT-1:0]   rx_dout,
    input  logic              rd_en,
    input  logic              ovr_clr,
    output logic [DBIT-1:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    output logic              timeout
);

    localparam int DEPTH = 2**ADDR_W;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              pop, wr, drop;

    assign empty       = count == '0;
    assign full        = count == (ADDR_W+1)'(DEPTH);
    assign almost_full = count >= (ADDR_W+1)'(AFULL_LVL);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign pop  = rd_en && !empty;
    assign wr   = rx_done && (!full || pop);
    assign drop = rx_done && full && !pop;

    uart_rx_fifo_mem #(.DBIT(DBIT), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_addr (wr_ptr),
        .wr_data (rx_dout),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr && !pop) count <= count + (ADDR_W+1)'(1);
            else if (pop && !wr) count <= count - (ADDR_W+1)'(1);
            overrun <= drop || (overrun && !ovr_clr);
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TOUT_TICKS = tout_ticks(TOUT_CHARS, DBIT, BIT_WIDTH);
    localparam int TW         = $clog2(TOUT_TICKS);

    tout_state_e    state, state_nx;
    logic [TW-1:0]  tcnt, tcnt_nx;
    logic           act;

    assign act     = wr || pop;
    assign timeout = state == T_FLAG;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= T_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        case (state)
            T_IDLE: begin
                if (!empty) begin
                    state_nx = T_COUNT;
                    tcnt_nx  = '0;
                end
            end
            T_COUNT: begin
                if (empty) state_nx = T_IDLE;
                else if (act) tcnt_nx = '0;
                else if (s_tick) begin
                    if (tcnt == TW'(TOUT_TICKS - 1)) state_nx = T_FLAG;
                    else tcnt_nx = tcnt + TW'(1);
                end
            end
            T_FLAG: begin
                if (empty) state_nx = T_IDLE;
                else if (act) begin
                    state_nx = T_COUNT;
                    tcnt_nx  = '0;
                end
            end
            default: state_nx = T_IDLE;
        endcase
    end
`else
    logic unused_s_tick;
    assign unused_s_tick = s_tick;
    assign timeout       = 1'b0;
`endif

endmodule
